// File: rtl/bcd_stopwatch_core.sv
// bcd_stopwatch_core
// MM:SS stopwatch feeding the 4-digit seven-segment scan driver. Raw buttons
// are synchronized, debounced and turned into one-cycle pulses. A start/pause/
// clear FSM gates a prescaler and a saturating packed-BCD time counter.
//
// Optional feature macro: STOPWATCH_LAP_EN (adds btn_lap and a lap-hold display)
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   btn_start  raw start/pause button, active high, asynchronous to clk
//   btn_clear  raw clear button, active high, asynchronous to clk
//   btn_lap    raw lap button (STOPWATCH_LAP_EN only)
//   nums       packed BCD {min tens, min units, sec tens, sec units}
//   running    high while in RUN
//   done       high while in DONE (saturated at 59:59)

// Button conditioner: 2-FF sync, DEB_LEN-sample debounce, rising-edge pulse.
module bcd_stopwatch_btn #(
    parameter int DEB_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int FILL = DEB_LEN + 2;
    localparam int FW   = $clog2(FILL + 1);

    logic               sync1_q, sync2_q;
    logic [DEB_LEN-1:0] sh_q;
    logic               level_q, level_prev_q, armed_q;
    logic [FW-1:0]      fill_q;
    logic               filled;

    // filled: every bit of sh_q now holds a real post-reset sample
    assign filled = (fill_q == FW'(FILL));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sh_q         <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            armed_q      <= 1'b0;
            fill_q       <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            sh_q    <= {sh_q[DEB_LEN-2:0], sync2_q};
            if (!filled)
                fill_q <= fill_q + 1'b1;
            if (&sh_q)
                level_q <= 1'b1;
            else if (~|sh_q)
                level_q <= 1'b0;
            level_prev_q <= level_q;
            // A button held across reset must be seen released before it
            // may produce a pulse, so arm only on a real debounced low.
            if (filled && ~|sh_q)
                armed_q <= 1'b1;
        end
    end

    assign pulse_o = level_q & ~level_prev_q & armed_q;
endmodule

// State table:
//   S_IDLE  | cleared, nums=0000, waiting for start
//   S_RUN   | prescaler counting, time increments on tick
//   S_PAUSE | prescaler and time frozen
//   S_DONE  | saturated at 59:59, only clear leaves
module bcd_stopwatch_core #(
    parameter int TICK_DIV = 100_000_000,
    parameter int DEB_LEN  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic        btn_lap,
`endif
    output logic [15:0] nums,
    output logic        running,
    output logic        done
);
    localparam int              PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   P_MAX = PW'(TICK_DIV - 1);
    localparam logic [15:0]     T_MAX = 16'h5959;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [15:0]   cnt_q;
    logic          running_q, done_q;
    logic          start_p, clear_p, tick, at_max;
    logic [15:0]   cnt_inc, cnt_run;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (v[7:4] == 4'd5) begin
                r[7:4] = 4'd0;
                if (v[11:8] == 4'd9) begin
                    r[11:8]  = 4'd0;
                    r[15:12] = v[15:12] + 4'd1;
                end else begin
                    r[11:8] = v[11:8] + 4'd1;
                end
            end else begin
                r[7:4] = v[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    bcd_stopwatch_btn #(.DEB_LEN(DEB_LEN)) u_btn_start (
        .clk(clk), .rst(rst), .btn_i(btn_start), .pulse_o(start_p)
    );
    bcd_stopwatch_btn #(.DEB_LEN(DEB_LEN)) u_btn_clear (
        .clk(clk), .rst(rst), .btn_i(btn_clear), .pulse_o(clear_p)
    );

    assign tick    = (state_q == S_RUN) && (presc_q == P_MAX);
    assign at_max  = (cnt_q == T_MAX);
    assign cnt_inc = bcd_inc(cnt_q);
    assign cnt_run = tick ? cnt_inc : cnt_q;

`ifdef STOPWATCH_LAP_EN
    logic        lap_p, lap_hold_q;
    // disp_q doubles as the lap register: while holding it simply stops following the count
    logic [15:0] disp_q;

    bcd_stopwatch_btn #(.DEB_LEN(DEB_LEN)) u_btn_lap (
        .clk(clk), .rst(rst), .btn_i(btn_lap), .pulse_o(lap_p)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_hold_q <= 1'b0;
            disp_q     <= '0;
`endif
        end else if (clear_p) begin
            // clear has priority over start and tick in every state
            state_q   <= S_IDLE;
            presc_q   <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_hold_q <= 1'b0;
            disp_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    presc_q <= '0;
                    cnt_q   <= '0;
                    if (start_p) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    presc_q <= tick ? '0 : presc_q + 1'b1;
                    if (tick && at_max) begin
                        // saturate instead of wrapping past 59:59
                        state_q   <= S_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
`ifdef STOPWATCH_LAP_EN
                        lap_hold_q <= 1'b0;
                        disp_q     <= T_MAX;
`endif
                    end else begin
                        cnt_q <= cnt_run;
                        if (start_p) begin
                            state_q   <= S_PAUSE;
                            running_q <= 1'b0;
                        end
`ifdef STOPWATCH_LAP_EN
                        if (lap_p && !lap_hold_q) begin
                            lap_hold_q <= 1'b1;
                            disp_q     <= cnt_q;   // pre-increment value
                        end else if (lap_p) begin
                            lap_hold_q <= 1'b0;
                            disp_q     <= cnt_run;
                        end else if (!lap_hold_q) begin
                            disp_q <= cnt_run;
                        end
`endif
                    end
                end
                S_PAUSE: begin
                    if (start_p) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    presc_q <= '0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef STOPWATCH_LAP_EN
    assign nums = disp_q;
`else
    assign nums = cnt_q;
`endif
    assign running = running_q;
    assign done    = done_q;
endmodule

// File: tb/tb_bcd_stopwatch_core.sv
module tb_bcd_stopwatch_core;
    localparam int TICK_DIV = 4;
    localparam int DEB_LEN  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_start = 1'b0;
    logic        btn_clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    logic        btn_lap = 1'b0;
`endif
    logic [15:0] nums;
    logic        running, done;

    bcd_stopwatch_core #(.TICK_DIV(TICK_DIV), .DEB_LEN(DEB_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
`ifdef STOPWATCH_LAP_EN
        .btn_lap   (btn_lap),
`endif
        .nums      (nums),
        .running   (running),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] n;
        logic        r;
        logic        d;
    } obs_t;

    obs_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          snap_req = 0;
    int          snap_done = 0;
    logic        mon_en = 1'b0;
    logic [17:0] prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // seconds -> MM:SS packed BCD, computed arithmetically
    function automatic logic [15:0] bcd_of(input int s);
        int mm = s / 60;
        int ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic legal(input logic [15:0] v);
        return (v[15:12] <= 4'd5) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    task automatic push(input logic [15:0] n, input logic r, input logic d);
        obs_t o;
        o.n = n; o.r = r; o.d = d;
        exp_q.push_back(o);
    endtask

    // Monitor: every change of {nums,running,done}, or an explicit snapshot
    // request, pops one expected observation.
    always @(negedge clk) begin : monitor
        logic [17:0] cur;
        obs_t        e;
        cur = {nums, running, done};
        if (!mon_en) begin
            prev = cur;
        end else if (snap_req != snap_done || cur !== prev) begin
            if (snap_req != snap_done) snap_done = snap_done + 1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=no_change (t=%0t)", cur, $time);
            end else begin
                e = exp_q.pop_front();
                check("output", 32'(cur), 32'(e));
            end
            if (cur !== prev) check("bcd_legal", 32'(legal(nums)), 32'd1);
            prev = cur;
        end
    end

    task automatic press(input int mask, input int hold);
        btn_start = mask[0];
        btn_clear = mask[1];
`ifdef STOPWATCH_LAP_EN
        btn_lap = mask[2];
`endif
        repeat (hold) @(posedge clk);
        #1;
        btn_start = 1'b0;
        btn_clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        btn_lap = 1'b0;
`endif
    endtask

    task automatic wait_nums(input logic [15:0] v, input int budget, input string name);
        int n = 0;
        while (nums !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(nums), 32'(v));
    endtask

    task automatic wait_run(input logic v, input int budget, input string name);
        int n = 0;
        while (running !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(running), 32'(v));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t0, t1;
        // reset state
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 mon_en = 1'b1;
        push(16'h0000, 1'b0, 1'b0);
        snap_req = snap_req + 1;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // bounce then stable press -> one pulse; carry run to 10:02 and pause
        push(16'h0000, 1'b1, 1'b0);
        for (int s = 1; s <= 602; s++) push(bcd_of(s), 1'b1, 1'b0);
        push(16'h1002, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            btn_start = ~btn_start;
            @(posedge clk);
            #1;
        end
        btn_start = 1'b1;
        t0 = cyc;
        wait_run(1'b1, 12, "bounce_start");
        check("start_latency_ok", 32'((cyc - t0 >= 6) && (cyc - t0 <= 8)), 32'd1);
        repeat (3) @(posedge clk);
        #1 btn_start = 1'b0;
        wait_nums(16'h1000, 3000, "carry_1000");
        // press so the pause lands 2 prescaler cycles after tick 602
        repeat (3) @(posedge clk);
        #1 press(1, 6);
        wait_run(1'b0, 30, "pause");
        repeat (100) @(posedge clk);
        #1;

        // resume: partial second continues; then tick and pause coincide
        push(16'h1002, 1'b1, 1'b0);
        push(16'h1003, 1'b1, 1'b0);
        push(16'h1004, 1'b1, 1'b0);
        push(16'h1005, 1'b1, 1'b0);
        push(16'h1006, 1'b0, 1'b0);
        btn_start = 1'b1;
        wait_run(1'b1, 12, "resume");
        t0 = cyc;
        btn_start = 1'b0;
        wait_nums(16'h1003, 10, "resume_tick");
        check("resume_tick_delay", 32'(cyc - t0), 32'd2);
        t1 = cyc;
        wait_nums(16'h1004, 10, "next_tick");
        check("tick_spacing", 32'(cyc - t1), 32'd4);
        @(posedge clk);
        #1 press(1, 6);
        wait_run(1'b0, 20, "pause_on_tick");

        // start and clear pulses in the same cycle while paused: clear wins
        repeat (10) @(posedge clk);
        #1;
        push(16'h0000, 1'b0, 1'b0);
        press(3, 6);
        repeat (20) @(posedge clk);
        #1;

        // saturate at 59:59, start ignored in DONE, clear returns to IDLE
        push(16'h0000, 1'b1, 1'b0);
        for (int s = 1; s <= 3599; s++) push(bcd_of(s), 1'b1, 1'b0);
        push(16'h5959, 1'b0, 1'b1);
        press(1, 6);
        begin
            int n = 0;
            while (done !== 1'b1 && n < 15000) begin
                @(negedge clk);
                n++;
            end
        end
        check("done_reached", 32'(done), 32'd1);
        repeat (2) @(posedge clk);
        #1 press(1, 6);
        repeat (30) @(posedge clk);
        #1;
        push(16'h0000, 1'b0, 1'b0);
        press(2, 6);
        repeat (20) @(posedge clk);
        #1;

`ifdef STOPWATCH_LAP_EN
        // lap at 00:05 freezes display across three ticks, second lap shows 00:08
        push(16'h0000, 1'b1, 1'b0);
        for (int s = 1; s <= 5; s++) push(bcd_of(s), 1'b1, 1'b0);
        push(16'h0008, 1'b1, 1'b0);
        push(16'h0009, 1'b1, 1'b0);
        press(1, 6);
        wait_nums(16'h0004, 40, "lap_pre");
        press(4, 4);
        repeat (7) @(posedge clk);
        #1 press(4, 4);
        wait_nums(16'h0009, 40, "lap_release");
        push(16'h0000, 1'b0, 1'b0);
        press(2, 6);
        repeat (20) @(posedge clk);
        #1;
`endif

        // asynchronous reset mid-run, button held across reset release
        push(16'h0000, 1'b1, 1'b0);
        push(16'h0001, 1'b1, 1'b0);
        push(16'h0002, 1'b1, 1'b0);
        push(16'h0000, 1'b0, 1'b0);
        press(1, 6);
        wait_nums(16'h0002, 40, "pre_reset");
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("async_reset", 32'({nums, running, done}), 32'd0);
        btn_start = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1 btn_start = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // fresh press works; clear arriving together with a tick wins
        push(16'h0000, 1'b1, 1'b0);
        push(16'h0001, 1'b1, 1'b0);
        push(16'h0000, 1'b0, 1'b0);
        press(1, 6);
        wait_run(1'b1, 10, "start_after_reset");
        @(posedge clk);
        #1 press(2, 6);
        repeat (20) @(posedge clk);
        #1;

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
